util_axis_uart_tx_arb: RTL and testbench
========================================

Name: util_axis_uart_tx_arb

Overview:
Round-robin arbiter that shares one util_axis_uart_tx byte stream between num_req AXIS requesters, e.g. debug console, status reporter and command responder.
- Grants one requester at a time.
- With lock_on_tlast=1, holds the grant until that requester's tlast beat so messages are never interleaved on txd.
- Optional idle timeout frees a stalled requester.
- Sits directly in front of the UART TX s_axis port.

Parameters:
num_req, 4, number of requesters (2..16)
data_bits, 8, beat width; matches the UART TX data_bits
lock_on_tlast, 1, 1 = hold grant until tlast beat; 0 = re-arbitrate after every beat
timeout_cycles, 0, 0 = disabled; else release grant after this many consecutive cycles with granted tvalid low

Ports:
aclk  in  1  clock
arst  in  1  asynchronous reset, active-high
s_axis_tdata  in  num_req*data_bits  requester data; requester i occupies bits [i*data_bits +: data_bits]
s_axis_tvalid  in  num_req  per-requester valid
s_axis_tlast  in  num_req  per-requester end of message
s_axis_tready  out  num_req  per-requester ready
m_axis_tdata  out  data_bits  to UART TX s_axis_tdata
m_axis_tvalid  out  1  to UART TX
m_axis_tready  in  1  from UART TX
grant  out  num_req  one-hot current grant; 0 when idle
busy  out  1  high while a grant is held

Behaviour:
- Reset (async assert, released sync to aclk):
  - s_axis_tready, m_axis_tvalid, grant, busy = 0.
  - m_axis_tdata = 0; last_grant = num_req-1, so requester 0 has first priority; timeout counter = 0.
- Output stage: one register slice.
  - s_axis_tready[g] = grant[g] & (~m_axis_tvalid | m_axis_tready).
  - All non-granted tready = 0.
  - Accepted beat loads m_axis_tdata and sets m_axis_tvalid; m_axis_tvalid clears when m_axis_tready=1 with no new beat.
- FSM states: IDLE, LOCKED.
  - IDLE: search s_axis_tvalid from index last_grant+1 upward with wrap; the first asserted index g is registered into grant, then go to LOCKED. No grant if no tvalid.
  - LOCKED:
    - Release when the granted beat is accepted and either lock_on_tlast=0 or tlast=1.
    - Release on timeout: timeout_cycles!=0, counter reaches timeout_cycles, and no beat is accepted that cycle.
    - On release: next state IDLE, last_grant=g, grant=0.
- Latency:
  - Grant asserts 1 cycle after tvalid is sampled in IDLE.
  - The first beat is accepted on the next edge and appears on m_axis 2 edges after tvalid is first sampled.
  - Within a message: 1 beat per cycle if m_axis_tready is held high.
- Re-arbitration: one idle bubble cycle (IDLE) between grants, which is acceptable given UART rate.
- Timeout counter:
  - Increments only in LOCKED while the granted tvalid is low.
  - Clears on any granted tvalid high and on entry to LOCKED.
  - Saturates at timeout_cycles.
- Boundaries:
  - Requester drops tvalid mid-message: grant held indefinitely when timeout_cycles=0.
  - tlast accepted while others pending: release, then next grant goes to the next index after g (fairness).
  - Only the last-granted requester is valid: it is re-granted after the bubble.
  - m_axis backpressure: the output register holds data and m_axis_tvalid stays high until accepted.
  - A beat in the output register is not lost on release; it drains normally.
  - Non-granted tvalid/tdata changes have no effect.
  - arst mid-message: the output register is discarded immediately and state returns to reset values.

Test Plan:
- Reset then req0 sends 3 beats 0x55,0x56,0x57 (tlast on 0x57), m_tready=1 -> grant=0001 one cycle after tvalid; m_axis shows 0x55,0x56,0x57 on consecutive cycles; busy drops after the tlast beat.
- req1 and req2 both valid with 2-beat messages (req1: 0xA0,0xA1; req2: 0xB0,0xB1), last_grant=0 -> order 0xA0,0xA1,0xB0,0xB1; no interleave; one idle cycle between.
- All 4 requesters continuously valid with 1-beat messages -> grants cycle 0,1,2,3,0,...; each requester gets 1 of every 4 beats.
- lock_on_tlast=1, req0 sends 0x11 without tlast then drops tvalid, req3 valid, timeout_cycles=8 -> grant stays 0001 for 8 cycles, releases, req3 granted; timeout_cycles=0 -> req3 never granted.
- m_axis_tready held low 20 cycles after the first beat 0x42 -> m_axis_tdata stable at 0x42, m_axis_tvalid=1, s_axis_tready=0 throughout; resumes with no loss or duplication.
- arst pulsed mid-message while m_axis_tvalid=1 -> m_axis_tvalid, grant, busy go 0 asynchronously; after release req0 wins first.

Source files
------------

// File: rtl/util_axis_uart_tx_arb.sv
// Round-robin AXIS arbiter feeding one UART TX byte stream.
// The grant is held per message (or per beat) and there is one output register slice.
module util_axis_uart_tx_arb #(
  parameter int num_req        = 4,
  parameter int data_bits      = 8,
  parameter bit lock_on_tlast  = 1'b1,
  parameter int timeout_cycles = 0
) (
  input  logic                           aclk,
  input  logic                           arst,
  input  logic [num_req*data_bits-1:0]   s_axis_tdata,
  input  logic [num_req-1:0]             s_axis_tvalid,
  input  logic [num_req-1:0]             s_axis_tlast,
  output logic [num_req-1:0]             s_axis_tready,
  output logic [data_bits-1:0]           m_axis_tdata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [num_req-1:0]             grant,
  output logic                           busy
);

  localparam int idx_w = (num_req > 1) ? $clog2(num_req) : 1;
  localparam int cnt_w = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(timeout_cycles);

  typedef enum logic [0:0] {st_idle, st_locked} state_t;

  state_t               state_q, state_d;
  logic [num_req-1:0]   grant_q, grant_d;
  logic [idx_w-1:0]     gnt_idx_q, gnt_idx_d;
  logic [idx_w-1:0]     last_q, last_d;
  logic [cnt_w-1:0]     cnt_q, cnt_d;
  logic [data_bits-1:0] m_tdata_q;
  logic                 m_tvalid_q;

  logic                 take;
  logic                 accept;
  logic                 g_valid;
  logic                 g_last;
  logic                 timeout_hit;
  logic                 found;
  logic [idx_w-1:0]     next_idx;
  logic [data_bits-1:0] acc_data;

  // valid/ready: a beat moves on any edge where tvalid and tready are both high;
  // the slice can take a beat when it is empty or is draining this cycle.
  assign take          = ~m_tvalid_q | m_axis_tready;
  assign s_axis_tready = grant_q & {num_req{take}};
  assign accept        = |(s_axis_tvalid & s_axis_tready);
  assign g_valid       = |(s_axis_tvalid & grant_q);
  assign g_last        = |(s_axis_tlast & grant_q);
  assign acc_data      = s_axis_tdata[gnt_idx_q*data_bits +: data_bits];
  assign timeout_hit   = (timeout_cycles != 0) && (cnt_q == cnt_max) && !accept;

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign grant         = grant_q;
  assign busy          = (state_q == st_locked);

  // Rotating priority search starting just after the last granted index.
  always_comb begin
    int j;
    found    = 1'b0;
    next_idx = '0;
    for (int k = 1; k <= num_req; k++) begin
      j = int'(last_q) + k;
      if (j >= num_req) j = j - num_req;
      if (!found && s_axis_tvalid[j]) begin
        found    = 1'b1;
        next_idx = idx_w'(j);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gnt_idx_d = gnt_idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    case (state_q)
      st_idle: begin
        cnt_d = '0;
        if (found) begin
          grant_d           = '0;
          grant_d[next_idx] = 1'b1;
          gnt_idx_d         = next_idx;
          state_d           = st_locked;
        end
      end
      st_locked: begin
        if ((accept && (!lock_on_tlast || g_last)) || timeout_hit) begin
          state_d = st_idle;
          last_d  = gnt_idx_q;
          grant_d = '0;
          cnt_d   = '0;
        end else if (g_valid) begin
          cnt_d = '0;
        end else if (cnt_q != cnt_max) begin
          cnt_d = cnt_q + cnt_w'(1);
        end
      end
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q   <= st_idle;
      grant_q   <= '0;
      gnt_idx_q <= '0;
      last_q    <= idx_w'(num_req - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gnt_idx_q <= gnt_idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  // Output slice: a held beat survives release of the grant and drains normally.
  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else if (accept) begin
      m_tdata_q  <= acc_data;
      m_tvalid_q <= 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_util_axis_uart_tx_arb.sv
// Directed bench for util_axis_uart_tx_arb: a default instance plus a second
// instance with an 8-cycle idle timeout sharing the same requester inputs.
module tb_util_axis_uart_tx_arb;

  logic        tb_data_clk = 1'b0;
  logic        arst;
  logic [31:0] s_tdata;
  logic [3:0]  s_tvalid, s_tlast;
  logic [3:0]  s_tready, s_tready_to;
  logic [7:0]  m_tdata, m_tdata_to;
  logic        m_tvalid, m_tvalid_to;
  logic        m_tready;
  logic [3:0]  grant, grant_to;
  logic        busy, busy_to;

  int          total = 0;
  int          bad = 0;
  logic [8:0]  src_q[4][$];
  logic [7:0]  out_log[$];
  logic [7:0]  exp_q[$];
  int          acc_log[$];
  int          nsteps;

  always #5 tb_data_clk = ~tb_data_clk;

  util_axis_uart_tx_arb #(.num_req(4), .data_bits(8), .lock_on_tlast(1'b1), .timeout_cycles(0)) dut (
    .aclk(tb_data_clk), .arst(arst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .grant(grant), .busy(busy)
  );

  util_axis_uart_tx_arb #(.num_req(4), .data_bits(8), .lock_on_tlast(1'b1), .timeout_cycles(8)) dut_to (
    .aclk(tb_data_clk), .arst(arst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready_to),
    .m_axis_tdata(m_tdata_to), .m_axis_tvalid(m_tvalid_to), .m_axis_tready(m_tready),
    .grant(grant_to), .busy(busy_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i]        = 1'b1;
        s_tdata[i*8 +: 8]  = src_q[i][0][7:0];
        s_tlast[i]         = src_q[i][0][8];
      end else begin
        s_tvalid[i]        = 1'b0;
        s_tdata[i*8 +: 8]  = 8'h00;
        s_tlast[i]         = 1'b0;
      end
    end
  endtask

  // One clock: record handshakes seen before the edge, then present the next beats.
  task automatic step();
    logic [3:0] acc;
    logic       fire;
    logic [7:0] fdata;
    acc   = s_tvalid & s_tready;
    fire  = m_tvalid & m_tready;
    fdata = m_tdata;
    @(posedge tb_data_clk);
    #1;
    if (fire) out_log.push_back(fdata);
    for (int i = 0; i < 4; i++) begin
      if (acc[i] && src_q[i].size() > 0) begin
        void'(src_q[i].pop_front());
        acc_log.push_back(i);
      end
    end
    drive();
    #1;
  endtask

  task automatic run_until(input int n, input int budget, output int steps);
    steps = 0;
    while (steps < budget && out_log.size() < n) begin
      step();
      steps++;
    end
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(out_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
      chk(tag, {24'h0, out_log[i]}, {24'h0, exp_q[i]});
    out_log.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    for (int i = 0; i < 4; i++) src_q[i].delete();
    out_log.delete();
    acc_log.delete();
    drive();
    repeat (2) @(posedge tb_data_clk);
    @(negedge tb_data_clk);
    arst = 1'b0;
    @(posedge tb_data_clk);
    #2;
  endtask

  initial begin
    m_tready = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    do_reset();

    // reset state
    chk("rst_grant", {28'h0, grant}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mvalid", {31'h0, m_tvalid}, 32'h0);
    chk("rst_mdata", {24'h0, m_tdata}, 32'h0);
    chk("rst_sready", {28'h0, s_tready}, 32'h0);

    // single 3-beat message from req0
    src_q[0].push_back({1'b0, 8'h55});
    src_q[0].push_back({1'b0, 8'h56});
    src_q[0].push_back({1'b1, 8'h57});
    drive();
    #1;
    step();
    chk("t1_grant", {28'h0, grant}, 32'h1);
    chk("t1_busy", {31'h0, busy}, 32'h1);
    chk("t1_sready", {28'h0, s_tready}, 32'h1);
    step();
    chk("t1_b0", {23'h0, m_tvalid, m_tdata}, 32'h155);
    step();
    chk("t1_b1", {23'h0, m_tvalid, m_tdata}, 32'h156);
    step();
    chk("t1_b2", {23'h0, m_tvalid, m_tdata}, 32'h157);
    chk("t1_busy_end", {31'h0, busy}, 32'h0);
    chk("t1_grant_end", {28'h0, grant}, 32'h0);
    step();
    chk("t1_drained", {31'h0, m_tvalid}, 32'h0);
    exp_q = '{8'h55, 8'h56, 8'h57};
    check_log("t1_out");
    acc_log.delete();

    // req1 and req2 contend after req0 was last granted
    src_q[1].push_back({1'b0, 8'hA0});
    src_q[1].push_back({1'b1, 8'hA1});
    src_q[2].push_back({1'b0, 8'hB0});
    src_q[2].push_back({1'b1, 8'hB1});
    drive();
    #1;
    run_until(4, 40, nsteps);
    chk("t2_cycles", 32'(nsteps), 32'd7);
    exp_q = '{8'hA0, 8'hA1, 8'hB0, 8'hB1};
    check_log("t2_out");
    chk("t2_acc_len", 32'(acc_log.size()), 32'd4);
    if (acc_log.size() == 4) begin
      chk("t2_acc0", 32'(acc_log[0]), 32'd1);
      chk("t2_acc1", 32'(acc_log[1]), 32'd1);
      chk("t2_acc2", 32'(acc_log[2]), 32'd2);
      chk("t2_acc3", 32'(acc_log[3]), 32'd2);
    end

    // all four requesters with two 1-beat messages each
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src_q[i].push_back({1'b1, 8'(i * 16)});
      src_q[i].push_back({1'b1, 8'(i * 16 + 1)});
    end
    drive();
    #1;
    run_until(8, 60, nsteps);
    chk("t3_cycles", 32'(nsteps), 32'd17);
    exp_q = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
    check_log("t3_out");
    chk("t3_acc_len", 32'(acc_log.size()), 32'd8);
    for (int i = 0; i < 8 && i < acc_log.size(); i++)
      chk("t3_acc", 32'(acc_log[i]), 32'(i % 4));

    // output backpressure holds the beat
    do_reset();
    m_tready = 1'b0;
    src_q[0].push_back({1'b0, 8'h42});
    src_q[0].push_back({1'b0, 8'h43});
    src_q[0].push_back({1'b1, 8'h44});
    drive();
    #1;
    step();
    step();
    chk("t5_first", {23'h0, m_tvalid, m_tdata}, 32'h142);
    for (int c = 0; c < 20; c++) begin
      step();
      chk("t5_hold", {19'h0, s_tready, m_tvalid, m_tdata}, 32'h142);
    end
    m_tready = 1'b1;
    #1;
    run_until(3, 20, nsteps);
    chk("t5_empty", {31'h0, m_tvalid}, 32'h0);
    exp_q = '{8'h42, 8'h43, 8'h44};
    check_log("t5_out");

    // stalled req0 mid-message, req3 waiting: timeout 8 vs disabled
    do_reset();
    m_tready = 1'b1;
    s_tvalid = 4'b1001;
    s_tlast  = 4'b1000;
    s_tdata  = 32'h3300_0011;
    @(posedge tb_data_clk); #2;
    chk("t4_grant", {24'h0, grant_to, grant}, 32'h11);
    @(posedge tb_data_clk); #2;
    chk("t4_beat", {16'h0, m_tdata_to, m_tdata}, 32'h1111);
    s_tvalid = 4'b1000;
    for (int c = 0; c < 8; c++) begin
      @(posedge tb_data_clk); #2;
      chk("t4_hold_to", {28'h0, grant_to}, 32'h1);
    end
    @(posedge tb_data_clk); #2;
    chk("t4_release", {27'h0, busy_to, grant_to}, 32'h0);
    @(posedge tb_data_clk); #2;
    chk("t4_regrant", {28'h0, grant_to}, 32'h8);
    @(posedge tb_data_clk); #2;
    chk("t4_req3_data", {23'h0, m_tvalid_to, m_tdata_to}, 32'h133);
    repeat (20) @(posedge tb_data_clk);
    #2;
    chk("t4_no_timeout", {27'h0, busy, grant}, 32'h11);
    chk("t4_req3_starved", {28'h0, s_tready}, 32'h1);

    // asynchronous reset while a beat is held
    do_reset();
    m_tready = 1'b0;
    src_q[0].push_back({1'b0, 8'h61});
    src_q[0].push_back({1'b0, 8'h62});
    src_q[0].push_back({1'b1, 8'h63});
    drive();
    #1;
    step();
    step();
    chk("t6_held", {23'h0, m_tvalid, m_tdata}, 32'h161);
    #1 arst = 1'b1;
    #1;
    chk("t6_async", {19'h0, busy, grant, m_tvalid, m_tdata}, 32'h0);
    chk("t6_async_sready", {28'h0, s_tready}, 32'h0);
    for (int i = 0; i < 4; i++) src_q[i].delete();
    out_log.delete();
    acc_log.delete();
    src_q[0].push_back({1'b1, 8'h70});
    src_q[1].push_back({1'b1, 8'h71});
    drive();
    @(negedge tb_data_clk);
    arst = 1'b0;
    @(posedge tb_data_clk); #2;
    chk("t6_first_win", {28'h0, grant}, 32'h1);
    m_tready = 1'b1;
    #1;
    run_until(2, 20, nsteps);
    exp_q = '{8'h70, 8'h71};
    check_log("t6_out");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
